// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter: per-source FIFOs feeding registered register-file write ports
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int NR_SRC         = 4,
    parameter int NR_WRITE_PORTS = 2,
    parameter int FIFO_DEPTH     = 2,
    parameter bit ZERO_REG_ZERO  = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic [NR_SRC-1:0]                    src_valid_i,
    output logic [NR_SRC-1:0]                    src_ready_o,
    input  logic [NR_SRC*5-1:0]                  src_waddr_i,
    input  logic [NR_SRC*DATA_WIDTH-1:0]         src_wdata_i,
    output logic [NR_WRITE_PORTS*5-1:0]          waddr_o,
    output logic [NR_WRITE_PORTS*DATA_WIDTH-1:0] wdata_o,
    output logic [NR_WRITE_PORTS-1:0]            we_o,
    output logic                                 busy_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RR_W  = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

    logic [CNT_W-1:0]      cnt_q    [NR_SRC];
    logic [PTR_W-1:0]      rd_q     [NR_SRC];
    logic [PTR_W-1:0]      wr_q     [NR_SRC];
    logic [4:0]            mem_addr [NR_SRC][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [NR_SRC][FIFO_DEPTH];
    logic [4:0]            head_addr[NR_SRC];
    logic [DATA_WIDTH-1:0] head_data[NR_SRC];
    logic [NR_SRC-1:0]     nonempty;
    logic [NR_SRC-1:0]     push;
    logic [NR_SRC-1:0]     pop;
    logic [RR_W-1:0]       rr_q;
    logic [RR_W-1:0]       rr_d;

    logic [NR_WRITE_PORTS-1:0] gnt_valid;
    logic [4:0]                gnt_addr[NR_WRITE_PORTS];
    logic [DATA_WIDTH-1:0]     gnt_data[NR_WRITE_PORTS];
    int                        nport;
    logic                      conflict;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int s = 0; s < NR_SRC; s++) begin
            nonempty[s]    = (cnt_q[s] != '0);
            src_ready_o[s] = (cnt_q[s] != CNT_W'(FIFO_DEPTH)) && !flush_i;
            push[s]        = src_valid_i[s] && src_ready_o[s];
            head_addr[s]   = mem_addr[s][rd_q[s]];
            head_data[s]   = mem_data[s][rd_q[s]];
        end
    end

    // Round-robin scan over FIFO heads; x0 heads are dropped without using a port,
    // and a head whose address is already granted this cycle waits.
    always_comb begin
        pop       = '0;
        gnt_valid = '0;
        rr_d      = rr_q;
        nport     = 0;
        conflict  = 1'b0;
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
            gnt_addr[p] = '0;
            gnt_data[p] = '0;
        end
        for (int i = 0; i < NR_SRC; i++) begin
            for (int s = 0; s < NR_SRC; s++) begin
                if (s == (int'(rr_q) + i) % NR_SRC && nonempty[s]) begin
                    if (ZERO_REG_ZERO && head_addr[s] == 5'd0) begin
                        pop[s] = 1'b1;
                        rr_d   = RR_W'((s + 1) % NR_SRC);
                    end else if (nport < NR_WRITE_PORTS) begin
                        conflict = 1'b0;
                        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                            if (p < nport && gnt_addr[p] == head_addr[s]) begin
                                conflict = 1'b1;
                            end
                        end
                        if (!conflict) begin
                            for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                                if (p == nport) begin
                                    gnt_valid[p] = 1'b1;
                                    gnt_addr[p]  = head_addr[s];
                                    gnt_data[p]  = head_data[s];
                                end
                            end
                            nport  = nport + 1;
                            pop[s] = 1'b1;
                            rr_d   = RR_W'((s + 1) % NR_SRC);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= '0;
            we_o    <= '0;
            waddr_o <= '0;
            wdata_o <= '0;
            for (int s = 0; s < NR_SRC; s++) begin
                cnt_q[s] <= '0;
                rd_q[s]  <= '0;
                wr_q[s]  <= '0;
            end
        end else if (flush_i) begin
            we_o <= '0;
            for (int s = 0; s < NR_SRC; s++) begin
                cnt_q[s] <= '0;
                rd_q[s]  <= '0;
                wr_q[s]  <= '0;
            end
        end else begin
            rr_q <= rr_d;
            we_o <= gnt_valid;
            for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                if (gnt_valid[p]) begin
                    waddr_o[p*5 +: 5]                   <= gnt_addr[p];
                    wdata_o[p*DATA_WIDTH +: DATA_WIDTH] <= gnt_data[p];
                end
            end
            for (int s = 0; s < NR_SRC; s++) begin
                if (push[s]) wr_q[s] <= ptr_inc(wr_q[s]);
                if (pop[s])  rd_q[s] <= ptr_inc(rd_q[s]);
                cnt_q[s] <= cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
            end
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the counters.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NR_SRC; s++) begin
            if (push[s]) begin
                mem_addr[s][wr_q[s]] <= src_waddr_i[s*5 +: 5];
                mem_data[s][wr_q[s]] <= src_wdata_i[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy_o = (|nonempty) || (|we_o);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         flush_i = 1'b0;
    logic [3:0]   src_valid_i = '0;
    logic [3:0]   src_ready_o;
    logic [19:0]  src_waddr_i = '0;
    logic [255:0] src_wdata_i = '0;
    logic [9:0]   waddr_o;
    logic [127:0] wdata_o;
    logic [1:0]   we_o;
    logic         busy_o;

    regfile_wb_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
        .src_waddr_i(src_waddr_i), .src_wdata_i(src_wdata_i),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        fl;
        logic [3:0]  v;
        logic [19:0] a;
        logic [31:0] d;
        logic [1:0]  we;
        logic [9:0]  wa;
        logic [15:0] wd;
        logic        busy;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [255:0] exp_d(input logic [31:0] d8);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*64 +: 8] = d8[k*8 +: 8];
        return r;
    endfunction

    function automatic logic [127:0] exp_wd(input logic [15:0] d8);
        logic [127:0] r;
        r = '0;
        r[7:0]    = d8[7:0];
        r[71:64]  = d8[15:8];
        return r;
    endfunction

    task automatic drive(input logic fl, input logic [3:0] v, input logic [19:0] a, input logic [255:0] d);
        flush_i     = fl;
        src_valid_i = v;
        src_waddr_i = a;
        src_wdata_i = d;
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Reference model: per-source queues and a round-robin index.
    typedef struct packed {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t         mq[4][$];
    int           m_rr;
    logic [1:0]   m_we;
    logic [9:0]   m_wa;
    logic [127:0] m_wd;

    task automatic model_step(input logic fl, input logic [3:0] v, input logic [19:0] a, input logic [255:0] d);
        logic [3:0] acc;
        int         used, last, s;
        logic [4:0] taken0;
        ent_t       e;
        ent_t       ne;
        for (int k = 0; k < 4; k++) acc[k] = v[k] && !fl && (mq[k].size() < 2);
        m_we = '0;
        if (fl) begin
            for (int k = 0; k < 4; k++) mq[k].delete();
            return;
        end
        used   = 0;
        last   = -1;
        taken0 = '0;
        for (int i = 0; i < 4; i++) begin
            s = (m_rr + i) % 4;
            if (mq[s].size() == 0) continue;
            e = mq[s][0];
            if (e.a == 5'd0) begin
                void'(mq[s].pop_front());
                last = s;
                continue;
            end
            if (used == 2) continue;
            if (used == 1 && taken0 == e.a) continue;
            if (used == 0) begin
                taken0 = e.a;
                m_we[0] = 1'b1; m_wa[4:0] = e.a; m_wd[63:0] = e.d;
            end else begin
                m_we[1] = 1'b1; m_wa[9:5] = e.a; m_wd[127:64] = e.d;
            end
            used++;
            void'(mq[s].pop_front());
            last = s;
        end
        if (last >= 0) m_rr = (last + 1) % 4;
        for (int k = 0; k < 4; k++) begin
            if (acc[k]) begin
                ne.a = a[k*5 +: 5];
                ne.d = d[k*64 +: 64];
                mq[k].push_back(ne);
            end
        end
    endtask

    task automatic rand_cycle(input logic fl, input logic [3:0] v, input logic [19:0] a, input logic [255:0] d);
        logic [3:0] rdy;
        logic       bsy;
        drive(fl, v, a, d);
        for (int k = 0; k < 4; k++) rdy[k] = (mq[k].size() < 2) && !fl;
        #1;
        check("rand_ready", src_ready_o, rdy);
        model_step(fl, v, a, d);
        step();
        bsy = (m_we != 0);
        for (int k = 0; k < 4; k++) if (mq[k].size() != 0) bsy = 1'b1;
        check("rand_we", we_o, m_we);
        check("rand_waddr", waddr_o, m_wa);
        check("rand_wdata", wdata_o, m_wd);
        check("rand_busy", busy_o, bsy);
    endtask

    initial begin
        logic [3:0]   v;
        logic [19:0]  a;
        logic [255:0] d;
        logic         fl;

        tbl[0]  = '{1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, 32'h000000A5, 2'b00, {5'd0, 5'd0}, 16'h0000, 1'b1};
        tbl[1]  = '{1'b0, 4'b0000, 20'd0, 32'h0, 2'b01, {5'd0, 5'd5}, 16'h00A5, 1'b1};
        tbl[2]  = '{1'b0, 4'b0000, 20'd0, 32'h0, 2'b00, {5'd0, 5'd5}, 16'h00A5, 1'b0};
        tbl[3]  = '{1'b0, 4'b1000, {5'd0, 5'd0, 5'd0, 5'd0}, 32'h77000000, 2'b00, {5'd0, 5'd5}, 16'h00A5, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 20'd0, 32'h0, 2'b00, {5'd0, 5'd5}, 16'h00A5, 1'b0};
        tbl[5]  = '{1'b0, 4'b0000, 20'd0, 32'h0, 2'b00, {5'd0, 5'd5}, 16'h00A5, 1'b0};
        tbl[6]  = '{1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 32'h40302010, 2'b00, {5'd0, 5'd5}, 16'h00A5, 1'b1};
        tbl[7]  = '{1'b0, 4'b0000, 20'd0, 32'h0, 2'b11, {5'd2, 5'd1}, 16'h2010, 1'b1};
        tbl[8]  = '{1'b0, 4'b0000, 20'd0, 32'h0, 2'b11, {5'd4, 5'd3}, 16'h4030, 1'b1};
        tbl[9]  = '{1'b0, 4'b0000, 20'd0, 32'h0, 2'b00, {5'd4, 5'd3}, 16'h4030, 1'b0};
        tbl[10] = '{1'b0, 4'b0110, {5'd0, 5'd7, 5'd7, 5'd0}, 32'h00221100, 2'b00, {5'd4, 5'd3}, 16'h4030, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 20'd0, 32'h0, 2'b01, {5'd4, 5'd7}, 16'h4011, 1'b1};
        tbl[12] = '{1'b0, 4'b0000, 20'd0, 32'h0, 2'b01, {5'd4, 5'd7}, 16'h4022, 1'b1};
        tbl[13] = '{1'b0, 4'b0000, 20'd0, 32'h0, 2'b00, {5'd4, 5'd7}, 16'h4022, 1'b0};

        #12;
        check("reset_we", we_o, 2'b00);
        check("reset_waddr", waddr_o, 10'd0);
        check("reset_wdata", wdata_o, 128'd0);
        check("reset_busy", busy_o, 1'b0);
        check("reset_ready", src_ready_o, 4'b1111);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].fl, tbl[i].v, tbl[i].a, exp_d(tbl[i].d));
            step();
            check($sformatf("tbl%0d_we", i), we_o, tbl[i].we);
            check($sformatf("tbl%0d_waddr", i), waddr_o, tbl[i].wa);
            check($sformatf("tbl%0d_wdata", i), wdata_o, exp_wd(tbl[i].wd));
            check($sformatf("tbl%0d_busy", i), busy_o, tbl[i].busy);
        end

        // Flush with three entries pending.
        drive(1'b0, 4'b0111, {5'd0, 5'd11, 5'd10, 5'd9}, exp_d(32'h00030201));
        step();
        check("flush_pending_busy", busy_o, 1'b1);
        drive(1'b1, 4'b0000, 20'd0, '0);
        #1;
        check("flush_ready_low", src_ready_o, 4'b0000);
        step();
        check("flush_we", we_o, 2'b00);
        check("flush_busy", busy_o, 1'b0);
        drive(1'b0, 4'b0000, 20'd0, '0);
        step();
        check("post_flush_we", we_o, 2'b00);
        check("post_flush_busy", busy_o, 1'b0);
        check("post_flush_ready", src_ready_o, 4'b1111);

        // Asynchronous reset in the middle of a burst.
        drive(1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, exp_d(32'h44332211));
        step();
        drive(1'b0, 4'b0000, 20'd0, '0);
        step();
        check("burst_we", we_o, 2'b11);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_we", we_o, 2'b00);
        check("midrst_waddr", waddr_o, 10'd0);
        check("midrst_wdata", wdata_o, 128'd0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_ready", src_ready_o, 4'b1111);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int k = 0; k < 4; k++) mq[k].delete();
        m_rr = 0;
        m_we = '0;
        m_wa = '0;
        m_wd = '0;
        for (int c = 0; c < 400; c++) begin
            v  = (c < 10) ? 4'b1111 : 4'($urandom_range(0, 15));
            fl = (c >= 10) && ($urandom_range(0, 49) == 0);
            for (int k = 0; k < 4; k++) begin
                a[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            end
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
            rand_cycle(fl, v, a, d);
        end
        for (int c = 0; c < 8; c++) rand_cycle(1'b0, 4'b0000, 20'd0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
